// File: rtl/div_unit_if.sv
// div_unit_if: divide request (start/op/operands/rd) and register-file writeback bundle
interface div_unit_if #(parameter int WIDTH = 32, parameter int AW = 5);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [AW-1:0] rd_addr;
  logic busy;
  logic done;
  logic we3;
  logic [AW-1:0] a3;
  logic [WIDTH-1:0] wd3;
  modport master(output start, op, rs1_val, rs2_val, rd_addr, input busy, done, we3, a3, wd3);
  modport slave(input start, op, rs1_val, rs2_val, rd_addr, output busy, done, we3, a3, wd3);
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring RV32M divider; define DIV_FAST_EN to send divide-by-zero and signed overflow straight to DONE
module div_unit #(parameter int WIDTH = 32, parameter int AW = 5) (
  input logic clk,
  input logic reset,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic [AW-1:0] rd_q, a3_q;
  logic [WIDTH-1:0] a_raw, dvs, quo, rem, wd3_q, res, a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0] rem_sh, diff;
  logic neg_q, neg_r, div0, ovf, sgn_in, div0_in, ovf_in, fast_in, accept, done_w;
  assign sgn_in = ~bus.op[0];
  assign div0_in = bus.rs2_val == '0;
  assign ovf_in = sgn_in && bus.rs1_val == MIN && bus.rs2_val == '1;
`ifdef DIV_FAST_EN
  assign fast_in = div0_in || ovf_in;
`else
  assign fast_in = 1'b0;
`endif
  assign a_abs = sgn_in && bus.rs1_val[WIDTH-1] ? -bus.rs1_val : bus.rs1_val;
  assign b_abs = sgn_in && bus.rs2_val[WIDTH-1] ? -bus.rs2_val : bus.rs2_val;
  assign accept = state == IDLE && bus.start;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff = rem_sh - {1'b0, dvs};
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;
  assign res = div0 ? (op_q[1] ? a_raw : '1) : ovf ? (op_q[1] ? '0 : MIN) : op_q[1] ? r_fix : q_fix;
  assign done_w = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.done = done_w;
  assign bus.we3 = done_w && rd_q != '0;
  assign bus.a3 = done_w ? rd_q : a3_q;
  assign bus.wd3 = done_w ? res : wd3_q;
  always_comb
    state_nx = state == IDLE ? (bus.start ? (fast_in ? DONE : CALC) : IDLE) : state == CALC ? (cnt == '0 ? DONE : CALC) : IDLE;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      op_q <= '0;
      rd_q <= '0;
      a3_q <= '0;
      a_raw <= '0;
      dvs <= '0;
      quo <= '0;
      rem <= '0;
      wd3_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      cnt <= CW'(WIDTH);
      op_q <= bus.op;
      rd_q <= bus.rd_addr;
      a_raw <= bus.rs1_val;
      dvs <= b_abs;
      quo <= a_abs;
      rem <= '0;
      neg_q <= sgn_in && (bus.rs1_val[WIDTH-1] ^ bus.rs2_val[WIDTH-1]);
      neg_r <= sgn_in && bus.rs1_val[WIDTH-1];
      div0 <= div0_in;
      ovf <= ovf_in;
    end else if (state == CALC && cnt != '0) begin
      rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
      cnt <= cnt - CW'(1);
    end else if (done_w) begin
      a3_q <= rd_q;
      wd3_q <= res;
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit covering directed RV32M cases, busy/reset behaviour and random operands
module tb_div_unit;
  localparam int W = 32;
`ifdef DIV_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef struct {logic [4:0] a3; logic [W-1:0] wd3; logic we3; int lat;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  exp_t sb[$];
  div_unit_if #(.WIDTH(W), .AW(5)) bus();
  div_unit #(.WIDTH(W), .AW(5)) dut(.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    if (!op[0] && a == 32'h8000_0000 && b == '1) return op[1] ? '0 : 32'h8000_0000;
    case (op)
      2'd0: return $signed(a) / $signed(b);
      2'd1: return a / b;
      2'd2: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction
  function automatic bit special(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return b == '0 || (!op[0] && a == 32'h8000_0000 && b == '1);
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd, output int at);
    bus.op = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_addr = rd;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    at = cyc;
  endtask
  task automatic push(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd);
    exp_t e;
    e.a3 = rd;
    e.wd3 = model(op, a, b);
    e.we3 = rd != 5'd0;
    e.lat = FAST && special(op, a, b) ? 0 : W + 1;
    sb.push_back(e);
  endtask
  task automatic wait_done(input string tag, input int at);
    exp_t e;
    int k = 0;
    while (!bus.done && k < 200) begin
      step();
      k++;
    end
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_sb"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"}, cyc - at, e.lat);
      chk({tag, "_a3"}, bus.a3, e.a3);
      chk({tag, "_wd3"}, bus.wd3, e.wd3);
      chk({tag, "_we3"}, bus.we3, e.we3);
      chk({tag, "_busy"}, bus.busy, 1);
      step();
      chk({tag, "_busy_after"}, bus.busy, 0);
      chk({tag, "_done_after"}, {bus.done, bus.we3}, 0);
      chk({tag, "_hold"}, {bus.a3, bus.wd3}, {e.a3, e.wd3});
    end
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd);
    int at;
    push(op, a, b, rd);
    issue(op, a, b, rd, at);
    wait_done(tag, at);
  endtask
  initial begin
    int at, dummy, d0;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0;
    bus.op = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_addr = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_we3", bus.we3, 0);
    chk("rst_a3", bus.a3, 0);
    chk("rst_wd3", bus.wd3, 0);
    run("div_100_7", 2'd0, 100, 7, 5);
    run("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 2, 3);
    run("div_m7_2", 2'd0, 32'hFFFF_FFF9, 2, 3);
    run("divu_by0", 2'd1, 42, 0, 4);
    run("remu_by0", 2'd3, 42, 0, 4);
    run("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 6);
    run("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6);
    push(2'd1, 50, 5, 0);
    issue(2'd1, 50, 5, 0, at);
    d0 = done_cnt;
    repeat (5) step();
    issue(2'd0, 77, 3, 7, dummy);
    wait_done("x0_ignored", at);
    repeat (5) step();
    chk("x0_one_pulse", done_cnt - d0, 1);
    d0 = done_cnt;
    issue(2'd0, 1000, 10, 9, dummy);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done_we3", {bus.done, bus.we3}, 0);
    chk("abort_outs", {bus.a3, bus.wd3}, 0);
    repeat (W + 5) step();
    chk("abort_no_pulse", done_cnt - d0, 0);
    run("div_9_3", 2'd0, 9, 3, 9);
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = i % 2 ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 0) rb = -rb;
      run($sformatf("rand%0d", i), rop, ra, rb, 5'($urandom_range(1, 31)));
    end
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
